// File: rtl/dcache_ctrl_pkg.sv
// dcache_ctrl shared types: FSM encodings, field widths, byte select.
// Used by dcache_ctrl and dcache_line_array.
package dcache_ctrl_pkg;

  localparam int INDEX_BITS  = 3;
  localparam int TAG_BITS    = 6 - INDEX_BITS;
  localparam int OFFSET_BITS = 2;
  localparam int BLOCK_WIDTH = 32;
  localparam int LINES       = 1 << INDEX_BITS;

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_WRITEBACK = 2'd1,
    S_FETCH     = 2'd2,
    S_FILL      = 2'd3
  } state_e;

  function automatic logic [7:0] sel_byte(
    input logic [BLOCK_WIDTH-1:0] blk,
    input logic [OFFSET_BITS-1:0] off
  );
    return blk[{off, 3'b000} +: 8];
  endfunction

endpackage

// File: rtl/dcache_line_array.sv
// dcache line storage: valid/dirty/tag/data, async read, sync write.
// Byte-write port for store hits, full-line port for refill.
module dcache_line_array
  import dcache_ctrl_pkg::*;
(
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [INDEX_BITS-1:0]  idx_i,
  output logic                   valid_o,
  output logic                   dirty_o,
  output logic [TAG_BITS-1:0]    tag_o,
  output logic [BLOCK_WIDTH-1:0] data_o,
  input  logic                   bwe_i,
  input  logic [OFFSET_BITS-1:0] boff_i,
  input  logic [7:0]             bdata_i,
  input  logic                   fwe_i,
  input  logic [TAG_BITS-1:0]    ftag_i,
  input  logic [BLOCK_WIDTH-1:0] fdata_i
);

  logic [LINES-1:0]       valid_q;
  logic [LINES-1:0]       dirty_q;
  logic [TAG_BITS-1:0]    tag_q  [LINES];
  logic [BLOCK_WIDTH-1:0] data_q [LINES];

  assign valid_o = valid_q[idx_i];
  assign dirty_o = dirty_q[idx_i];
  assign tag_o   = tag_q[idx_i];
  assign data_o  = data_q[idx_i];

  // Status bits: cleared on reset, set/cleared by refill and store hits
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else if (fwe_i) begin
      valid_q[idx_i] <= 1'b1;
      dirty_q[idx_i] <= 1'b0;
    end else if (bwe_i) begin
      dirty_q[idx_i] <= 1'b1;
    end
  end

  // Tag and data arrays carry no reset; validity guards them
  always_ff @(posedge clk_i) begin
    if (fwe_i) begin
      tag_q[idx_i]  <= ftag_i;
      data_q[idx_i] <= fdata_i;
    end else if (bwe_i) begin
      data_q[idx_i][{boff_i, 3'b000} +: 8] <= bdata_i;
    end
  end

endmodule

// File: rtl/dcache_ctrl.sv
// Direct-mapped write-back write-allocate data cache controller.
// Optional hit/miss counters enabled by defining DCACHE_STATS_EN.
module dcache_ctrl
  import dcache_ctrl_pkg::*;
(
  input  logic                   CLK,
  input  logic                   RESET,
  input  logic                   READ,
  input  logic                   WRITE,
  input  logic [7:0]             ADDRESS,
  input  logic [7:0]             WRITEDATA,
  output logic [7:0]             READDATA,
  output logic                   BUSYWAIT,
  output logic                   MEM_READ,
  output logic                   MEM_WRITE,
  output logic [5:0]             MEM_ADDRESS,
  output logic [BLOCK_WIDTH-1:0] MEM_WRITEDATA,
  input  logic [BLOCK_WIDTH-1:0] MEM_READDATA,
  input  logic                   MEM_BUSYWAIT
`ifdef DCACHE_STATS_EN
  ,
  output logic [15:0]            HIT_COUNT,
  output logic [15:0]            MISS_COUNT
`endif
);

  state_e state_q, state_d;

  logic [TAG_BITS-1:0]    req_tag;
  logic [INDEX_BITS-1:0]  req_idx;
  logic [OFFSET_BITS-1:0] req_off;
  logic                   req;

  // Miss address captured when leaving IDLE, so the refill lands
  // in the right line even if the CPU misbehaves mid-miss.
  logic [TAG_BITS-1:0]    mtag_q;
  logic [INDEX_BITS-1:0]  midx_q;
  logic [BLOCK_WIDTH-1:0] fill_q;

  logic [INDEX_BITS-1:0]  arr_idx;
  logic                   l_valid;
  logic                   l_dirty;
  logic [TAG_BITS-1:0]    l_tag;
  logic [BLOCK_WIDTH-1:0] l_data;

  logic hit;
  logic bwe;
  logic fwe;
  logic miss_start;

  assign req_tag = ADDRESS[7 -: TAG_BITS];
  assign req_idx = ADDRESS[OFFSET_BITS +: INDEX_BITS];
  assign req_off = ADDRESS[OFFSET_BITS-1:0];
  assign req     = READ | WRITE;

  assign arr_idx = (state_q == S_IDLE) ? req_idx : midx_q;
  assign hit     = req & l_valid & (l_tag == req_tag);

  dcache_line_array u_lines (
    .clk_i   (CLK),
    .rst_i   (RESET),
    .idx_i   (arr_idx),
    .valid_o (l_valid),
    .dirty_o (l_dirty),
    .tag_o   (l_tag),
    .data_o  (l_data),
    .bwe_i   (bwe),
    .boff_i  (req_off),
    .bdata_i (WRITEDATA),
    .fwe_i   (fwe),
    .ftag_i  (mtag_q),
    .fdata_i (fill_q)
  );

  // State register
  always_ff @(posedge CLK) begin
    if (RESET) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next state, CPU-side and memory-side outputs
  always_comb begin
    state_d       = state_q;
    BUSYWAIT      = 1'b0;
    READDATA      = 8'h00;
    MEM_READ      = 1'b0;
    MEM_WRITE     = 1'b0;
    MEM_ADDRESS   = 6'h00;
    MEM_WRITEDATA = '0;
    bwe           = 1'b0;
    fwe           = 1'b0;
    miss_start    = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (req) begin
          if (hit) begin
            if (WRITE) bwe = ~RESET;
            else       READDATA = sel_byte(l_data, req_off);
          end else begin
            BUSYWAIT   = 1'b1;
            miss_start = 1'b1;
            state_d    = (l_valid & l_dirty) ? S_WRITEBACK
                                             : S_FETCH;
          end
        end
      end
      S_WRITEBACK: begin
        BUSYWAIT      = 1'b1;
        MEM_WRITE     = 1'b1;
        MEM_ADDRESS   = {l_tag, midx_q};
        MEM_WRITEDATA = l_data;
        if (!MEM_BUSYWAIT) state_d = S_FETCH;
      end
      S_FETCH: begin
        BUSYWAIT    = 1'b1;
        MEM_READ    = 1'b1;
        MEM_ADDRESS = {mtag_q, midx_q};
        if (!MEM_BUSYWAIT) state_d = S_FILL;
      end
      S_FILL: begin
        BUSYWAIT = 1'b1;
        fwe      = ~RESET;
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Miss address and refill block capture
  always_ff @(posedge CLK) begin
    if (miss_start) begin
      mtag_q <= req_tag;
      midx_q <= req_idx;
    end
    if (state_q == S_FETCH && !MEM_BUSYWAIT) begin
      fill_q <= MEM_READDATA;
    end
  end

`ifdef DCACHE_STATS_EN
  logic        pend_q;
  logic [15:0] hit_q;
  logic [15:0] miss_q;

  assign HIT_COUNT  = hit_q;
  assign MISS_COUNT = miss_q;

  // Saturating counters; a request that missed is not re-counted
  // when it later hits after the refill.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      pend_q <= 1'b0;
      hit_q  <= '0;
      miss_q <= '0;
    end else begin
      if (state_q == S_IDLE) pend_q <= miss_start;
      if (state_q == S_IDLE && hit && !pend_q && hit_q != 16'hFFFF)
        hit_q <= hit_q + 16'd1;
      if (miss_start && miss_q != 16'hFFFF)
        miss_q <= miss_q + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_dcache_ctrl.sv
// Directed self-checking bench for dcache_ctrl with a simple
// fixed-latency block memory model.
module tb_dcache_ctrl;

  localparam int LAT = 5;

  logic        clk;
  logic        RESET;
  logic        READ;
  logic        WRITE;
  logic [7:0]  ADDRESS;
  logic [7:0]  WRITEDATA;
  logic [7:0]  READDATA;
  logic        BUSYWAIT;
  logic        MEM_READ;
  logic        MEM_WRITE;
  logic [5:0]  MEM_ADDRESS;
  logic [31:0] MEM_WRITEDATA;
  logic [31:0] MEM_READDATA;
  logic        MEM_BUSYWAIT;
`ifdef DCACHE_STATS_EN
  logic [15:0] HIT_COUNT;
  logic [15:0] MISS_COUNT;
`endif

  int n_cmp = 0;
  int n_err = 0;

  dcache_ctrl dut (
    .CLK           (clk),
    .RESET         (RESET),
    .READ          (READ),
    .WRITE         (WRITE),
    .ADDRESS       (ADDRESS),
    .WRITEDATA     (WRITEDATA),
    .READDATA      (READDATA),
    .BUSYWAIT      (BUSYWAIT),
    .MEM_READ      (MEM_READ),
    .MEM_WRITE     (MEM_WRITE),
    .MEM_ADDRESS   (MEM_ADDRESS),
    .MEM_WRITEDATA (MEM_WRITEDATA),
    .MEM_READDATA  (MEM_READDATA),
    .MEM_BUSYWAIT  (MEM_BUSYWAIT)
`ifdef DCACHE_STATS_EN
    ,
    .HIT_COUNT     (HIT_COUNT),
    .MISS_COUNT    (MISS_COUNT)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // memory model: each request completes on its LAT-th cycle
  logic [31:0] mem [64];
  logic        load;
  logic [1:0]  req_c;
  logic [1:0]  req_l;
  int          mcnt;
  int          mcnt_eff;

  function automatic logic [31:0] init_val(input int i);
    case (i)
      1:       return 32'hDDCCBBAA;
      9:       return 32'h44332211;
      17:      return 32'h87654321;
      default: return 32'h0;
    endcase
  endfunction

  assign req_c = {MEM_READ, MEM_WRITE};
  always_comb begin
    mcnt_eff = 0;
    if (req_c == req_l) mcnt_eff = mcnt;
  end
  assign MEM_BUSYWAIT = (req_c != 2'b00) && (mcnt_eff != LAT - 1);
  assign MEM_READDATA = mem[MEM_ADDRESS];

  always @(posedge clk) begin
    req_l <= req_c;
    mcnt  <= (req_c != 2'b00) ? mcnt_eff + 1 : 0;
    if (load) begin
      for (int i = 0; i < 64; i++) mem[i] <= init_val(i);
    end else if (MEM_WRITE && !MEM_BUSYWAIT) begin
      mem[MEM_ADDRESS] <= MEM_WRITEDATA;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Observe one miss until BUSYWAIT drops, with a cycle budget.
  task automatic run_miss(input string nm, output int n_wb,
                          output int n_fe, output int n_tot,
                          output logic [5:0] wb_a,
                          output logic [5:0] fe_a,
                          output logic [31:0] wb_d,
                          output logic both);
    n_wb = 0; n_fe = 0; n_tot = 0;
    wb_a = '0; fe_a = '0; wb_d = '0; both = 1'b0;
    while (BUSYWAIT && n_tot < 40) begin
      if (MEM_WRITE) begin
        n_wb++;
        wb_a = MEM_ADDRESS;
        wb_d = MEM_WRITEDATA;
      end
      if (MEM_READ) begin
        n_fe++;
        fe_a = MEM_ADDRESS;
      end
      if (MEM_READ && MEM_WRITE) both = 1'b1;
      n_tot++;
      @(negedge clk);
      #1;
    end
    chk({nm, " done"}, 32'(n_tot < 40), 32'd1);
  endtask

  typedef struct {
    logic       rd;
    logic       wr;
    logic [7:0] addr;
    logic [7:0] wdata;
    logic       busy;
    logic [7:0] rdata;
  } vec_t;

  vec_t tv [8];

  int          nwb, nfe, ntot;
  logic [5:0]  wba, fea;
  logic [31:0] wbd;
  logic        bth;

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    tv[0] = '{1'b0, 1'b1, 8'h06, 8'h3C, 1'b0, 8'h00};
    tv[1] = '{1'b1, 1'b0, 8'h06, 8'h00, 1'b0, 8'h3C};
    tv[2] = '{1'b1, 1'b0, 8'h05, 8'h00, 1'b0, 8'hBB};
    tv[3] = '{1'b1, 1'b0, 8'h04, 8'h00, 1'b0, 8'hAA};
    tv[4] = '{1'b1, 1'b0, 8'h07, 8'h00, 1'b0, 8'hDD};
    tv[5] = '{1'b0, 1'b0, 8'h04, 8'h00, 1'b0, 8'h00};
    tv[6] = '{1'b1, 1'b1, 8'h04, 8'h55, 1'b0, 8'h00};
    tv[7] = '{1'b1, 1'b0, 8'h04, 8'h00, 1'b0, 8'h55};

    RESET = 1'b1; READ = 1'b0; WRITE = 1'b0;
    ADDRESS = 8'h00; WRITEDATA = 8'h00; load = 1'b1;
    repeat (2) @(negedge clk);
    load = 1'b0;
    #1;
    chk("rst BUSYWAIT", 32'(BUSYWAIT), 32'd0);
    chk("rst READDATA", 32'(READDATA), 32'd0);
    chk("rst MEM_READ", 32'(MEM_READ), 32'd0);
    chk("rst MEM_WRITE", 32'(MEM_WRITE), 32'd0);
    chk("rst MEM_ADDRESS", 32'(MEM_ADDRESS), 32'd0);
    chk("rst MEM_WRITEDATA", MEM_WRITEDATA, 32'd0);
`ifdef DCACHE_STATS_EN
    chk("rst HIT_COUNT", 32'(HIT_COUNT), 32'd0);
    chk("rst MISS_COUNT", 32'(MISS_COUNT), 32'd0);
`endif
    @(negedge clk);
    RESET = 1'b0;

    // cold read miss
    READ = 1'b1; ADDRESS = 8'h05;
    #1;
    chk("cold busy", 32'(BUSYWAIT), 32'd1);
    chk("cold idle memrd", 32'(MEM_READ), 32'd0);
    run_miss("cold", nwb, nfe, ntot, wba, fea, wbd, bth);
    chk("cold wb cycles", 32'(nwb), 32'd0);
    chk("cold fetch cycles", 32'(nfe), 32'd5);
    chk("cold fetch addr", 32'(fea), 32'h01);
    chk("cold stall", 32'(ntot), 32'd7);
    chk("cold rdata", 32'(READDATA), 32'hBB);
    @(negedge clk);

    // hit vectors on resident line 1
    for (int i = 0; i < 8; i++) begin
      READ = tv[i].rd; WRITE = tv[i].wr;
      ADDRESS = tv[i].addr; WRITEDATA = tv[i].wdata;
      #1;
      chk($sformatf("vec%0d busy", i), 32'(BUSYWAIT),
          32'(tv[i].busy));
      chk($sformatf("vec%0d rdata", i), 32'(READDATA),
          32'(tv[i].rdata));
      chk($sformatf("vec%0d memreq", i),
          32'({MEM_READ, MEM_WRITE}), 32'd0);
      @(negedge clk);
    end
    WRITE = 1'b0;

    // dirty eviction: index 1 tag 0 -> tag 1
    READ = 1'b1; ADDRESS = 8'h25;
    #1;
    run_miss("dirty", nwb, nfe, ntot, wba, fea, wbd, bth);
    chk("dirty wb cycles", 32'(nwb), 32'd5);
    chk("dirty wb addr", 32'(wba), 32'h01);
    chk("dirty wb data", wbd, 32'hDD3CBB55);
    chk("dirty fetch cycles", 32'(nfe), 32'd5);
    chk("dirty fetch addr", 32'(fea), 32'h09);
    chk("dirty both high", 32'(bth), 32'd0);
    chk("dirty stall", 32'(ntot), 32'd12);
    chk("dirty rdata", 32'(READDATA), 32'h22);
    chk("dirty mem landed", mem[1], 32'hDD3CBB55);
    @(negedge clk);

    // clean eviction back to tag 0
    ADDRESS = 8'h05;
    #1;
    run_miss("clean", nwb, nfe, ntot, wba, fea, wbd, bth);
    chk("clean wb cycles", 32'(nwb), 32'd0);
    chk("clean fetch addr", 32'(fea), 32'h01);
    chk("clean stall", 32'(ntot), 32'd7);
    chk("clean rdata", 32'(READDATA), 32'hBB);
    @(negedge clk);
`ifdef DCACHE_STATS_EN
    #1;
    chk("stats hits", 32'(HIT_COUNT), 32'd7);
    chk("stats misses", 32'(MISS_COUNT), 32'd3);
    @(negedge clk);
`endif

    // reset during fetch
    ADDRESS = 8'h2A;
    @(negedge clk);
    #1;
    chk("rfetch memrd", 32'(MEM_READ), 32'd1);
    chk("rfetch addr", 32'(MEM_ADDRESS), 32'h0A);
    RESET = 1'b1; READ = 1'b0;
    @(negedge clk);
    #1;
    chk("rfetch memrd drop", 32'(MEM_READ), 32'd0);
    chk("rfetch busy drop", 32'(BUSYWAIT), 32'd0);
    chk("rfetch memwr", 32'(MEM_WRITE), 32'd0);
`ifdef DCACHE_STATS_EN
    chk("rfetch hits clr", 32'(HIT_COUNT), 32'd0);
    chk("rfetch miss clr", 32'(MISS_COUNT), 32'd0);
`endif
    RESET = 1'b0;
    @(negedge clk);
    READ = 1'b1; ADDRESS = 8'h05;
    #1;
    chk("remiss busy", 32'(BUSYWAIT), 32'd1);
    run_miss("remiss", nwb, nfe, ntot, wba, fea, wbd, bth);
    chk("remiss stall", 32'(ntot), 32'd7);
    chk("remiss rdata", 32'(READDATA), 32'hBB);
    @(negedge clk);

    // request dropped mid-miss: refill still completes
    ADDRESS = 8'h45;
    #1;
    chk("drop busy", 32'(BUSYWAIT), 32'd1);
    @(negedge clk);
    READ = 1'b0;
    #1;
    run_miss("drop", nwb, nfe, ntot, wba, fea, wbd, bth);
    chk("drop stall", 32'(ntot), 32'd6);
    chk("drop fetch addr", 32'(fea), 32'h11);
    @(negedge clk);
    READ = 1'b1;
    #1;
    chk("drop hit busy", 32'(BUSYWAIT), 32'd0);
    chk("drop hit rdata", 32'(READDATA), 32'h43);
    @(negedge clk);
    READ = 1'b0;
`ifdef DCACHE_STATS_EN
    #1;
    chk("stats2 hits", 32'(HIT_COUNT), 32'd1);
    chk("stats2 misses", 32'(MISS_COUNT), 32'd2);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
